fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit.sv | 140 ++++++++++++++
 tb/tb_fetch_unit.sv | 452 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// fetch_unit: IF stage with a 2-entry {pc,instr} buffer, one outstanding
// imem request, branch redirect with DRAIN of a stale in-flight response.
// Ports: clk/reset (sync, active-low); stall_ip holds the ID head;
//   branch_taken_ip/branch_target_ip redirect; imem_req/addr/gnt/rvalid/
//   rdata fetch bus; ID_instr/pc/valid present the buffer head;
//   stall_cnt_op counts stalled valid cycles when FETCH_STALL_CNT_EN is
//   defined, otherwise it is constant 0.
module fetch_unit #(
  parameter logic [31:0] BOOT_ADDR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall_ip,
  input  logic        branch_taken_ip,
  input  logic [31:0] branch_target_ip,
  output logic        imem_req_op,
  output logic [31:0] imem_addr_op,
  input  logic        imem_gnt_ip,
  input  logic        imem_rvalid_ip,
  input  logic [31:0] imem_rdata_ip,
  output logic [31:0] ID_instr_op,
  output logic [31:0] ID_pc_op,
  output logic        ID_valid_op,
  output logic [31:0] stall_cnt_op
);

  typedef enum logic {FETCH, DRAIN} state_t;

  state_t      state;
  logic [31:0] fetch_pc;
  logic [31:0] out_pc;
  logic        outstanding;
  logic [31:0] pc0, pc1;
  logic [31:0] ins0, ins1;
  logic [1:0]  count;

  logic        rv_ok;
  logic        pop;
  logic        push;
  logic        gnt;
  logic [1:0]  occ_next;
  logic        unused_tgt;

  assign unused_tgt = ^branch_target_ip[1:0];

  assign rv_ok    = imem_rvalid_ip && outstanding;
  assign pop      = (count != 2'd0) && !stall_ip;
  assign push     = (state == FETCH) && rv_ok
                  && !branch_taken_ip;
  assign occ_next = count - {1'b0, pop}
                  + {1'b0, push};

  // A new request may overlap the cycle its predecessor's
  // data returns, but only if the buffer still has room
  // for the data that request will bring back.
  assign imem_req_op = reset && (state == FETCH)
                     && !branch_taken_ip
                     && (!outstanding || imem_rvalid_ip)
                     && (occ_next < 2'd2);

  assign gnt          = imem_req_op && imem_gnt_ip;
  assign imem_addr_op = fetch_pc;
  assign ID_valid_op  = count != 2'd0;
  assign ID_pc_op     = pc0;
  assign ID_instr_op  = ins0;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= FETCH;
      fetch_pc    <= BOOT_ADDR;
      out_pc      <= '0;
      outstanding <= 1'b0;
      count       <= 2'd0;
      pc0         <= '0;
      pc1         <= '0;
      ins0        <= '0;
      ins1        <= '0;
    end else begin
      if (gnt) begin
        outstanding <= 1'b1;
        out_pc      <= fetch_pc;
        fetch_pc    <= fetch_pc + 32'd4;
      end else if (rv_ok) begin
        outstanding <= 1'b0;
      end

      unique case (state)
        FETCH: begin
          if (branch_taken_ip && outstanding
              && !imem_rvalid_ip)
            state <= DRAIN;
        end
        DRAIN: begin
          if (rv_ok)
            state <= FETCH;
        end
        default: state <= FETCH;
      endcase

      if (branch_taken_ip) begin
        fetch_pc <= {branch_target_ip[31:2], 2'b00};
        count    <= 2'd0;
      end else begin
        if (pop) begin
          pc0  <= pc1;
          ins0 <= ins1;
        end
        // Slot 0 takes the push when the buffer is
        // empty after this cycle's pop.
        if (push) begin
          if (count == {1'b0, pop}) begin
            pc0  <= out_pc;
            ins0 <= imem_rdata_ip;
          end else begin
            pc1  <= out_pc;
            ins1 <= imem_rdata_ip;
          end
        end
        count <= occ_next;
      end
    end
  end

`ifdef FETCH_STALL_CNT_EN
  logic [31:0] stall_cnt;

  always_ff @(posedge clk) begin
    if (!reset)
      stall_cnt <= '0;
    else if (ID_valid_op && stall_ip
             && (stall_cnt != '1))
      stall_cnt <= stall_cnt + 32'd1;
  end

  assign stall_cnt_op = stall_cnt;
`else
  assign stall_cnt_op = '0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed + random checks of fetch_unit against a
// queue-based model of the instruction stream and a one-slot memory.
module tb_fetch_unit;
  localparam logic [31:0] BOOT = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        stall_ip = 1'b0;
  logic        branch_taken_ip = 1'b0;
  logic [31:0] branch_target_ip = '0;
  logic        imem_req_op;
  logic [31:0] imem_addr_op;
  logic        imem_gnt_ip = 1'b0;
  logic        imem_rvalid_ip = 1'b0;
  logic [31:0] imem_rdata_ip = '0;
  logic [31:0] ID_instr_op;
  logic [31:0] ID_pc_op;
  logic        ID_valid_op;
  logic [31:0] stall_cnt_op;

  fetch_unit #(.BOOT_ADDR(BOOT)) dut (
    .clk              (clk),
    .reset            (reset),
    .stall_ip         (stall_ip),
    .branch_taken_ip  (branch_taken_ip),
    .branch_target_ip (branch_target_ip),
    .imem_req_op      (imem_req_op),
    .imem_addr_op     (imem_addr_op),
    .imem_gnt_ip      (imem_gnt_ip),
    .imem_rvalid_ip   (imem_rvalid_ip),
    .imem_rdata_ip    (imem_rdata_ip),
    .ID_instr_op      (ID_instr_op),
    .ID_pc_op         (ID_pc_op),
    .ID_valid_op      (ID_valid_op),
    .stall_cnt_op     (stall_cnt_op)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] ins;
  } ent_t;

  ent_t        q[$];
  logic [31:0] log_pc[$];
  int          log_cyc[$];
  logic [31:0] g_log[$];

  bit          m_busy = 0;
  bit          m_stale = 0;
  logic [31:0] m_addr = '0;
  int          m_wait = 0;
  int          lat_lo = 0;
  int          lat_hi = 0;
  logic [31:0] exp_fetch = BOOT;
  logic [31:0] cnt_m = '0;
  bit          p_hold = 0;
  bit          p_rst_low = 0;
  logic [31:0] p_addr = '0;
  logic        s_req, s_valid;
  logic [31:0] s_pc, s_ins, s_addr;
  int          cyc = 0;
  int          tests = 0;
  int          fails = 0;

  function automatic logic [31:0] word(input logic [31:0] a);
    return a * 32'd3 + 32'h13;
  endfunction

  task automatic tick(input bit rst_n, input bit st,
                      input bit br, input logic [31:0] tgt,
                      input bit gnt_en, input bit stale_rv);
    bit   rv, pop, push, granted;
    ent_t e;
    @(negedge clk);
    reset            = rst_n;
    stall_ip         = st;
    branch_taken_ip  = br;
    branch_target_ip = tgt;
    rv = (m_busy && m_wait == 0) || stale_rv;
    imem_rvalid_ip = rv;
    imem_rdata_ip  = !rv ? 32'h0 :
                     (m_busy ? word(m_addr) : 32'hDEAD_BEEF);
    imem_gnt_ip = 1'b0;
    #1;
    s_req   = imem_req_op;
    s_valid = ID_valid_op;
    s_pc    = ID_pc_op;
    s_ins   = ID_instr_op;
    s_addr  = imem_addr_op;
    pop  = (q.size() != 0) && !st;
    push = rv && m_busy && !m_stale && !br;
    if (!rst_n) begin
      tests++;
      if (imem_req_op !== 1'b0) begin
        fails++;
        $display("FAIL req_in_reset: got %b want 0", imem_req_op);
      end
      if (p_rst_low) begin
        tests++;
        if ({ID_valid_op, ID_pc_op, ID_instr_op, stall_cnt_op,
             imem_addr_op} !== {1'b0, 96'h0, BOOT}) begin
          fails++;
          $display("FAIL reset_values: v=%b pc=%h ins=%h cnt=%h addr=%h want 0/0/0/0/%h",
                   ID_valid_op, ID_pc_op, ID_instr_op,
                   stall_cnt_op, imem_addr_op, BOOT);
        end
      end
    end else begin
      tests++;
      if (ID_valid_op !== (q.size() != 0)) begin
        fails++;
        $display("FAIL id_valid: got %b want %b", ID_valid_op, q.size() != 0);
      end
      if (q.size() != 0) begin
        tests++;
        if (ID_pc_op !== q[0].pc || ID_instr_op !== q[0].ins) begin
          fails++;
          $display("FAIL id_head: got %h/%h want %h/%h",
                   ID_pc_op, ID_instr_op, q[0].pc, q[0].ins);
        end
      end
      tests++;
      if (imem_addr_op[1:0] !== 2'b00) begin
        fails++;
        $display("FAIL addr_align: got %h want low bits 00", imem_addr_op);
      end
      tests++;
      if (stall_cnt_op !== cnt_m) begin
        fails++;
        $display("FAIL stall_cnt: got %h want %h", stall_cnt_op, cnt_m);
      end
      if (imem_req_op === 1'b1) begin
        tests++;
        if ((m_busy && (!rv || m_stale))
            || (q.size() - int'(pop) + int'(push) >= 2)) begin
          fails++;
          $display("FAIL req_forbidden: got req=1 want 0 (busy=%b stale=%b occ=%0d)",
                   m_busy, m_stale, q.size());
        end
      end
      if (p_hold && !br) begin
        tests++;
        if (imem_req_op !== 1'b1 || imem_addr_op !== p_addr) begin
          fails++;
          $display("FAIL req_stable: got %b/%h want 1/%h",
                   imem_req_op, imem_addr_op, p_addr);
        end
      end
    end
    granted = gnt_en && rst_n && (imem_req_op === 1'b1);
    imem_gnt_ip = granted;
    @(posedge clk);
    cyc++;
    p_hold    = rst_n && (s_req === 1'b1) && !granted && !br;
    p_addr    = s_addr;
    p_rst_low = !rst_n;
    if (!rst_n) begin
      q.delete();
      m_busy    = 0;
      m_stale   = 0;
      exp_fetch = BOOT;
      cnt_m     = '0;
    end else begin
      if (q.size() != 0 && st && cnt_m != 32'hFFFF_FFFF) begin
`ifdef FETCH_STALL_CNT_EN
        cnt_m = cnt_m + 32'd1;
`endif
      end
      if (br) begin
        q.delete();
        if (m_busy && !rv) m_stale = 1;
        exp_fetch = {tgt[31:2], 2'b00};
      end else if (pop) begin
        e = q.pop_front();
        log_pc.push_back(e.pc);
        log_cyc.push_back(cyc);
      end
      if (push) q.push_back(ent_t'{pc: m_addr, ins: word(m_addr)});
      if (rv && m_busy) begin
        m_busy  = 0;
        m_stale = 0;
      end else if (m_busy && m_wait > 0) begin
        m_wait--;
      end
      if (granted) begin
        tests++;
        if (s_addr !== exp_fetch) begin
          fails++;
          $display("FAIL grant_addr: got %h want %h", s_addr, exp_fetch);
        end
        g_log.push_back(s_addr);
        exp_fetch = exp_fetch + 32'd4;
        m_busy  = 1;
        m_stale = 0;
        m_addr  = s_addr;
        m_wait  = $urandom_range(lat_hi, lat_lo);
      end
    end
  endtask

  task automatic test_reset();
    repeat (3) tick(0, 0, 0, 0, 0, 0);
    tick(1, 0, 0, 0, 0, 0);
    tests++;
    if (s_req !== 1'b1 || s_addr !== BOOT) begin
      fails++;
      $display("FAIL first_req: got %b/%h want 1/%h", s_req, s_addr, BOOT);
    end
  endtask

  task automatic test_stream();
    int n0, bad;
    lat_lo = 0;
    lat_hi = 0;
    n0 = log_pc.size();
    repeat (14) tick(1, 0, 0, 0, 1, 0);
    tests++;
    if (log_pc.size() - n0 < 10) begin
      fails++;
      $display("FAIL stream_len: got %0d want >= 10", log_pc.size() - n0);
    end else begin
      bad = 0;
      for (int i = 0; i < 3; i++)
        if (log_pc[n0 + i] !== BOOT + 32'(4 * i)) bad++;
      for (int i = n0 + 1; i < log_pc.size(); i++)
        if (log_cyc[i] != log_cyc[i - 1] + 1
            || log_pc[i] !== log_pc[i - 1] + 32'd4) bad++;
      if (bad != 0) begin
        fails++;
        $display("FAIL stream_order: got %0d bad entries want 0 (first %h)",
                 bad, log_pc[n0]);
      end
    end
  endtask

  task automatic test_stall_full();
    logic [31:0] hold_pc, hold_ins;
    int n0, bad;
    bad = 0;
    tick(1, 1, 0, 0, 1, 0);
    hold_pc  = ID_pc_op;
    hold_ins = ID_instr_op;
    for (int i = 0; i < 4; i++) begin
      tick(1, 1, 0, 0, 1, 0);
      if (s_req !== 1'b0 || s_pc !== hold_pc
          || s_ins !== hold_ins || s_valid !== 1'b1) bad++;
    end
    tests++;
    if (bad != 0) begin
      fails++;
      $display("FAIL stall_hold: got %0d bad cycles want 0 (req=%b pc=%h)",
               bad, s_req, s_pc);
    end
    n0 = log_pc.size();
    repeat (10) tick(1, 0, 0, 0, 1, 0);
    tests++;
    bad = 0;
    if (log_pc.size() - n0 < 5 || n0 == 0) bad++;
    else begin
      if (log_pc[n0] !== hold_pc) bad++;
      for (int i = n0; i < log_pc.size(); i++)
        if (log_pc[i] !== log_pc[i - 1] + 32'd4) bad++;
    end
    if (bad != 0) begin
      fails++;
      $display("FAIL stall_resume: got %0d bad entries want 0", bad);
    end
  endtask

  task automatic test_branch_drain();
    bit found;
    int n0, g0;
    repeat (2) tick(0, 0, 0, 0, 0, 0);
    tick(1, 0, 0, 0, 0, 0);
    lat_lo = 2;
    lat_hi = 2;
    found = 0;
    for (int i = 0; i < 30 && !found; i++) begin
      if (m_busy && m_addr == 32'h8 && m_wait > 0) found = 1;
      else tick(1, 0, 0, 0, 1, 0);
    end
    tests++;
    if (!found) begin
      fails++;
      $display("FAIL drain_setup: got no request to 8 outstanding want one");
    end
    n0 = log_pc.size();
    g0 = g_log.size();
    tick(1, 0, 1, 32'h103, 0, 0);
    tick(1, 0, 0, 0, 1, 0);
    tests++;
    if (s_req !== 1'b0 || s_valid !== 1'b0) begin
      fails++;
      $display("FAIL drain_idle: got req=%b valid=%b want 0/0", s_req, s_valid);
    end
    for (int i = 0; i < 20 && log_pc.size() == n0; i++)
      tick(1, 0, 0, 0, 1, 0);
    tests++;
    if (g_log.size() == g0 || g_log[g0] !== 32'h100) begin
      fails++;
      $display("FAIL drain_req: got %h want 00000100",
               g_log.size() > g0 ? g_log[g0] : 32'hX);
    end
    tests++;
    if (log_pc.size() == n0 || log_pc[n0] !== 32'h100) begin
      fails++;
      $display("FAIL drain_first_pc: got %h want 00000100",
               log_pc.size() > n0 ? log_pc[n0] : 32'hX);
    end
  endtask

  task automatic test_branch_rvalid_stall();
    bit found;
    int g0;
    logic [31:0] tgt;
    lat_lo = 1;
    lat_hi = 1;
    found = 0;
    for (int i = 0; i < 30 && !found; i++) begin
      if (m_busy && m_wait == 0 && !m_stale) found = 1;
      else tick(1, 1, 0, 0, 1, 0);
    end
    tests++;
    if (!found) begin
      fails++;
      $display("FAIL brv_setup: got no due response want one");
    end
    tgt = $urandom;
    g0 = g_log.size();
    tick(1, 1, 1, tgt, 0, 0);
    tick(1, 1, 0, 0, 1, 0);
    tests++;
    if (s_valid !== 1'b0) begin
      fails++;
      $display("FAIL brv_valid: got %b want 0", s_valid);
    end
    for (int i = 0; i < 10 && g_log.size() == g0; i++)
      tick(1, 1, 0, 0, 1, 0);
    tests++;
    if (g_log.size() == g0 || g_log[g0] !== {tgt[31:2], 2'b00}) begin
      fails++;
      $display("FAIL brv_req: got %h want %h",
               g_log.size() > g0 ? g_log[g0] : 32'hX, {tgt[31:2], 2'b00});
    end
  endtask

  task automatic test_reset_mid();
    bit found;
    int n0;
    lat_lo = 0;
    lat_hi = 0;
    for (int i = 0; i < 20 && q.size() < 2; i++)
      tick(1, 1, 0, 0, 1, 0);
    tick(0, 1, 0, 0, 0, 0);
    tick(1, 0, 0, 0, 0, 0);
    tests++;
    if ({s_valid, s_pc, s_ins, stall_cnt_op, s_addr, s_req}
        !== {1'b0, 96'h0, BOOT, 1'b1}) begin
      fails++;
      $display("FAIL rst_full: got v=%b pc=%h ins=%h cnt=%h addr=%h req=%b want 0/0/0/0/%h/1",
               s_valid, s_pc, s_ins, stall_cnt_op, s_addr, s_req, BOOT);
    end
    lat_lo = 2;
    lat_hi = 2;
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (m_busy && m_wait > 0 && q.size() != 0) found = 1;
      else tick(1, 0, 0, 0, 1, 0);
    end
    tests++;
    if (!found) begin
      fails++;
      $display("FAIL rst_setup: got no outstanding request want one");
    end
    tick(0, 0, 0, 0, 0, 0);
    n0 = log_pc.size();
    tick(1, 0, 0, 0, 1, 1);
    tests++;
    if (s_req !== 1'b1 || s_addr !== BOOT) begin
      fails++;
      $display("FAIL rst_req: got %b/%h want 1/%h", s_req, s_addr, BOOT);
    end
    tick(1, 0, 0, 0, 1, 0);
    tests++;
    if (s_valid !== 1'b0) begin
      fails++;
      $display("FAIL rst_stale: got valid=%b want 0", s_valid);
    end
    for (int i = 0; i < 20 && log_pc.size() == n0; i++)
      tick(1, 0, 0, 0, 1, 0);
    tests++;
    if (log_pc.size() == n0 || log_pc[n0] !== BOOT) begin
      fails++;
      $display("FAIL rst_first_pc: got %h want %h",
               log_pc.size() > n0 ? log_pc[n0] : 32'hX, BOOT);
    end
  endtask

  task automatic test_stall_cnt();
    logic [31:0] want;
    lat_lo = 0;
    lat_hi = 0;
    repeat (2) tick(0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 20 && q.size() == 0; i++)
      tick(1, 0, 0, 0, 1, 0);
    repeat (7) tick(1, 1, 0, 0, 1, 0);
    #1;
`ifdef FETCH_STALL_CNT_EN
    want = 32'd7;
`else
    want = 32'd0;
`endif
    tests++;
    if (stall_cnt_op !== want) begin
      fails++;
      $display("FAIL stall_cnt7: got %0d want %0d", stall_cnt_op, want);
    end
  endtask

  task automatic test_random();
    bit rst_n, st, br, g;
    logic [31:0] tgt;
    lat_lo = 0;
    lat_hi = 2;
    for (int i = 0; i < 800; i++) begin
      rst_n = $urandom_range(0, 99) != 0;
      st    = $urandom_range(0, 9) < 3;
      br    = $urandom_range(0, 99) < 5;
      tgt   = $urandom;
      if ($urandom_range(0, 3) == 0)
        tgt = 32'hFFFF_FFF0 | (tgt & 32'hF);
      g = !br && ($urandom_range(0, 9) < 7);
      tick(rst_n, st, br, tgt, g, 1'b0);
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_stall_full();
    test_branch_drain();
    test_branch_rvalid_stall();
    test_reset_mid();
    test_stall_cnt();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
